// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types and helpers for the data memory bank.
//   state_e     - controller state (ST_CLEAR after reset, ST_RUN afterwards)
//   clog2       - ceiling log2 for elaboration-time index sizing
//   byte_merge  - per-byte mux of a new word over an old word
//   lane_parity - even-parity bit for every byte lane of a word
// Helpers work on MAX_W-bit vectors; callers zero-extend and size-cast,
// so any DATA_W up to MAX_W is supported.
package data_memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int MAX_W = 1024;
    localparam int MAX_B = MAX_W / 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] byte_merge(input logic [MAX_W-1:0] old_w,
                                                    input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_B-1:0] be);
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < MAX_B; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    // Bit b is set when lane b has an odd number of ones, so storing it
    // alongside the byte makes each 9-bit lane even.
    function automatic logic [MAX_B-1:0] lane_parity(input logic [MAX_W-1:0] w);
        logic [MAX_B-1:0] p;
        for (int b = 0; b < MAX_B; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: DEPTH x (NUM_LANES*LANE_W) synchronous RAM.
//   clk, rst_n - clock, async active-low reset (read register only)
//   addr       - word index shared by write and read
//   we, be     - write strobe and per-lane enables
//   wdata      - write word, one LANE_W slice per lane
//   re         - read strobe; rdata is registered, read-first, holds otherwise
// The storage itself has no reset so it maps onto block RAM.
module data_memory_array #(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 8,
    parameter int DEPTH     = 256,
    parameter int IDX_W     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [IDX_W-1:0]                    addr,
    input  logic                                we,
    input  logic [NUM_LANES-1:0]                be,
    input  logic [NUM_LANES-1:0][LANE_W-1:0]    wdata,
    input  logic                                re,
    output logic [NUM_LANES-1:0][LANE_W-1:0]    rdata
);

    logic [NUM_LANES-1:0][LANE_W-1:0] mem [DEPTH];
    logic [NUM_LANES-1:0][LANE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (we && be[l]) mem[addr][l] <= wdata[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_bank.sv
// data_memory_bank: DEPTH x DATA_W data RAM between load/store and writeback.
//   clk, rst_n      - clock, async active-low reset
//   mem_access_addr - word address for reads and writes
//   mem_write_data, mem_write_en, mem_byte_en - byte-masked write request
//   mem_read        - read request; mem_read_data/mem_read_valid one cycle later
//   mem_ready       - high once the post-reset clear has finished
//   mem_addr_err    - pulse one cycle after an out-of-range request
//   mem_parity_err  - (DATA_MEMORY_BANK_PARITY_EN only) lane parity mismatch,
//                     pulses with mem_read_valid
// After reset every word is written with INIT_VALUE, one per cycle, before
// any request is accepted. Optional feature macro: DATA_MEMORY_BANK_PARITY_EN.
module data_memory_bank
    import data_memory_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                DEPTH      = 256,
    parameter int                ADDR_W     = 16,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   mem_access_addr,
    input  logic [DATA_W-1:0]   mem_write_data,
    input  logic                mem_write_en,
    input  logic [DATA_W/8-1:0] mem_byte_en,
    input  logic                mem_read,
    output logic [DATA_W-1:0]   mem_read_data,
    output logic                mem_read_valid,
    output logic                mem_ready,
    output logic                mem_addr_err
`ifdef DATA_MEMORY_BANK_PARITY_EN
    ,
    output logic                mem_parity_err
`endif
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int NB    = DATA_W / 8;
`ifdef DATA_MEMORY_BANK_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 rd_vld_q, rd_vld_d;
    logic                 err_q, err_d;
    logic                 fwd_q, fwd_d;        // last accepted read collided with a write
    logic                 zero_q, zero_d;      // last accepted read was out of range
    logic [DATA_W-1:0]    fwd_data_q, fwd_data_d;
    logic [NB-1:0]        fwd_be_q, fwd_be_d;

    logic                 run, addr_oor, wr_ok, rd_ok;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     arr_addr;
    logic                 arr_we;
    logic [NB-1:0]        arr_be;
    logic [NB-1:0][LANE_W-1:0] wr_lanes, init_lanes, arr_wdata, rd_lanes;
    logic [DATA_W-1:0]    rd_data, merged;

    assign idx = mem_access_addr[IDX_W-1:0];

    generate
        if (ADDR_W > IDX_W) begin : g_hi
            assign addr_oor = |mem_access_addr[ADDR_W-1:IDX_W];
        end else begin : g_nohi
            assign addr_oor = 1'b0;
        end
    endgenerate

`ifdef DATA_MEMORY_BANK_PARITY_EN
    logic [NB-1:0] wr_par, rd_par, out_par, fwd_par_q, fwd_par_d;
    assign wr_par = NB'(lane_parity(MAX_W'(mem_write_data)));
`endif

    // Lane packing between the word view and the RAM's per-lane view.
    for (genvar g = 0; g < NB; g++) begin : g_lane
`ifdef DATA_MEMORY_BANK_PARITY_EN
        assign wr_lanes[g]   = {wr_par[g], mem_write_data[8*g +: 8]};
        assign init_lanes[g] = {1'b0, INIT_VALUE[8*g +: 8]};
        assign rd_par[g]     = rd_lanes[g][8];
`else
        assign wr_lanes[g]   = mem_write_data[8*g +: 8];
        assign init_lanes[g] = INIT_VALUE[8*g +: 8];
`endif
        assign rd_data[8*g +: 8] = rd_lanes[g][7:0];
    end

    always_comb begin
        run        = (state_q == ST_RUN);
        wr_ok      = run && mem_write_en && !addr_oor;
        rd_ok      = run && mem_read;
        // The clear sequence owns the write port until it finishes.
        arr_addr   = run ? idx : cnt_q;
        arr_we     = !run || wr_ok;
        arr_be     = run ? mem_byte_en : '1;
        arr_wdata  = run ? wr_lanes : init_lanes;

        state_d    = state_q;
        cnt_d      = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
        end
        ready_d    = (state_d == ST_RUN);
        rd_vld_d   = rd_ok;
        err_d      = run && (mem_write_en || mem_read) && addr_oor;

        // Read-side bookkeeping changes only on an accepted read so the
        // output word holds between reads.
        fwd_d      = fwd_q;
        zero_d     = zero_q;
        fwd_data_d = fwd_data_q;
        fwd_be_d   = fwd_be_q;
`ifdef DATA_MEMORY_BANK_PARITY_EN
        fwd_par_d  = fwd_par_q;
`endif
        if (rd_ok) begin
            fwd_d      = wr_ok;    // shared address, so any write here hits the same word
            zero_d     = addr_oor;
            fwd_data_d = mem_write_data;
            fwd_be_d   = mem_byte_en;
`ifdef DATA_MEMORY_BANK_PARITY_EN
            fwd_par_d  = wr_par;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            err_q      <= 1'b0;
            fwd_q      <= 1'b0;
            zero_q     <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
`ifdef DATA_MEMORY_BANK_PARITY_EN
            fwd_par_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rd_vld_q   <= rd_vld_d;
            err_q      <= err_d;
            fwd_q      <= fwd_d;
            zero_q     <= zero_d;
            fwd_data_q <= fwd_data_d;
            fwd_be_q   <= fwd_be_d;
`ifdef DATA_MEMORY_BANK_PARITY_EN
            fwd_par_q  <= fwd_par_d;
`endif
        end
    end

    data_memory_array #(
        .NUM_LANES (NB),
        .LANE_W    (LANE_W),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (arr_addr),
        .we    (arr_we),
        .be    (arr_be),
        .wdata (arr_wdata),
        .re    (rd_ok),
        .rdata (rd_lanes)
    );

    // Write-first bypass: the RAM returns the pre-write word, new bytes
    // are laid over it here.
    assign merged         = DATA_W'(byte_merge(MAX_W'(rd_data), MAX_W'(fwd_data_q), MAX_B'(fwd_be_q)));
    assign mem_read_data  = zero_q ? '0 : (fwd_q ? merged : rd_data);
    assign mem_read_valid = rd_vld_q;
    assign mem_ready      = ready_q;
    assign mem_addr_err   = err_q;

`ifdef DATA_MEMORY_BANK_PARITY_EN
    assign out_par = zero_q ? '0 :
                     (fwd_q ? ((fwd_be_q & fwd_par_q) | (~fwd_be_q & rd_par)) : rd_par);
    assign mem_parity_err = rd_vld_q &&
                            (|(NB'(lane_parity(MAX_W'(mem_read_data))) ^ out_par));
`endif

endmodule

// File: tb/tb_data_memory_bank.sv
// Bench for data_memory_bank: DEPTH=8 instance checked cycle by cycle
// against an array model, plus a DEPTH=256 instance for address range.
module tb_data_memory_bank;

    localparam logic [15:0] INIT_A = 16'hA5A5;

    logic        clk, rst_n;
    logic        we, rd;
    logic [1:0]  be;
    logic [15:0] wd, addr;
    logic [15:0] a_data, b_data;
    logic        a_valid, a_ready, a_err, b_valid, b_ready, b_err;
`ifdef DATA_MEMORY_BANK_PARITY_EN
    logic        a_perr, b_perr;
`endif

    data_memory_bank #(.DATA_W(16), .DEPTH(8), .ADDR_W(16), .INIT_VALUE(INIT_A)) dut (
        .clk(clk), .rst_n(rst_n), .mem_access_addr(addr), .mem_write_data(wd),
        .mem_write_en(we), .mem_byte_en(be), .mem_read(rd),
        .mem_read_data(a_data), .mem_read_valid(a_valid), .mem_ready(a_ready),
        .mem_addr_err(a_err)
`ifdef DATA_MEMORY_BANK_PARITY_EN
        , .mem_parity_err(a_perr)
`endif
    );

    data_memory_bank #(.DATA_W(16), .DEPTH(256), .ADDR_W(16), .INIT_VALUE(16'h0000)) dut_b (
        .clk(clk), .rst_n(rst_n), .mem_access_addr(addr), .mem_write_data(wd),
        .mem_write_en(we), .mem_byte_en(be), .mem_read(rd),
        .mem_read_data(b_data), .mem_read_valid(b_valid), .mem_ready(b_ready),
        .mem_addr_err(b_err)
`ifdef DATA_MEMORY_BANK_PARITY_EN
        , .mem_parity_err(b_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk, n_fail, cyc;

    // Reference model of the DEPTH=8 instance.
    logic [15:0] m_mem [8];
    bit          m_run;
    int          m_cnt;
    logic [15:0] e_data;
    logic        e_valid, e_err, e_ready;
    logic        perr_exp;

    typedef struct {
        logic        we;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] x_data;
        logic        x_valid;
        logic        x_err;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cnt = 0;
        e_data = '0; e_valid = 0; e_err = 0; e_ready = 0;
    endtask

    // Apply one cycle of requests, advance the model, compare the DEPTH=8 DUT.
    task automatic step(input logic s_we, input logic [1:0] s_be, input logic [15:0] s_wd,
                        input logic s_rd, input logic [15:0] s_addr);
        logic oor;
        int   idx;
        we = s_we; be = s_be; wd = s_wd; rd = s_rd; addr = s_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (!m_run) begin
            m_mem[m_cnt] = INIT_A;
            m_cnt++;
            if (m_cnt == 8) m_run = 1;
            e_valid = 0;
            e_err   = 0;
        end else begin
            oor = (s_addr >= 16'd8);
            idx = int'(s_addr % 8);
            if (s_we && !oor) begin
                if (s_be[0]) m_mem[idx][7:0]  = s_wd[7:0];
                if (s_be[1]) m_mem[idx][15:8] = s_wd[15:8];
            end
            e_err   = (s_we || s_rd) && oor;
            e_valid = s_rd;
            if (s_rd) e_data = oor ? 16'h0000 : m_mem[idx];
        end
        e_ready = m_run;
        chk("ready", a_ready, e_ready);
        chk("valid", a_valid, e_valid);
        chk("addr_err", a_err, e_err);
        chk("rdata", a_data, e_data);
`ifdef DATA_MEMORY_BANK_PARITY_EN
        chk("parity_err", a_perr, perr_exp);
        perr_exp = 0;
`endif
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; perr_exp = 0;
        rst_n = 0; we = 0; rd = 0; be = 0; wd = 0; addr = 0;
        model_reset();

        tbl[0]  = '{1'b1, 2'b11, 16'h1234, 1'b0, 16'h0003, 16'hA5A5, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'b10, 16'hFF00, 1'b0, 16'h0003, 16'hA5A5, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0003, 16'hFF34, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 16'hFF34, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 2'b11, 16'h1111, 1'b0, 16'h0005, 16'hFF34, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 2'b01, 16'hBEEF, 1'b1, 16'h0005, 16'h11EF, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0005, 16'h11EF, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0105, 16'h0000, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 2'b11, 16'hDEAD, 1'b0, 16'h0105, 16'h0000, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0005, 16'h11EF, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0003, 16'hFF34, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'h0003, 16'hFF34, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 16'h0000, 1'b1, 16'h0003, 16'hFF34, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 2'b11, 16'h4321, 1'b1, 16'h0002, 16'h4321, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", a_data, 16'h0000);
        chk("rst_valid", a_valid, 1'b0);
        chk("rst_ready", a_ready, 1'b0);
        chk("rst_err", a_err, 1'b0);
        rst_n = 1; cyc = 0;

        // Clear: read requested every cycle must be ignored for 8 cycles
        for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 16'h0000, 1'b1, 16'(i));
        chk("clear_len", cyc, 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b00, 16'h0000, 1'b1, 16'(i));
            chk("clear_val", a_data, INIT_A);
        end

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].be, tbl[i].wd, tbl[i].rd, tbl[i].addr);
            chk($sformatf("vec%0d_valid", i), a_valid, tbl[i].x_valid);
            chk($sformatf("vec%0d_err", i), a_err, tbl[i].x_err);
            chk($sformatf("vec%0d_data", i), a_data, tbl[i].x_data);
        end

        // DEPTH=256 instance: wait out its clear (bounded)
        begin
            int k;
            k = 0;
            while (!b_ready && k < 400) begin idle(); k++; end
            chk("b_ready", b_ready, 1'b1);
            chk("b_clear_len", cyc, 256);
        end
        step(1'b1, 2'b11, 16'h7777, 1'b0, 16'h0005);
        chk("b_wr_err", b_err, 1'b0);
        step(1'b1, 2'b11, 16'hDEAD, 1'b0, 16'h0105);
        chk("b_oor_wr_err", b_err, 1'b1);
        chk("b_oor_wr_valid", b_valid, 1'b0);
        step(1'b0, 2'b00, 16'h0000, 1'b1, 16'h0005);
        chk("b_unchanged_valid", b_valid, 1'b1);
        chk("b_unchanged_data", b_data, 16'h7777);
        chk("b_unchanged_err", b_err, 1'b0);
        step(1'b0, 2'b00, 16'h0000, 1'b1, 16'h0105);
        chk("b_oor_rd_valid", b_valid, 1'b1);
        chk("b_oor_rd_data", b_data, 16'h0000);
        chk("b_oor_rd_err", b_err, 1'b1);
        idle();
        chk("b_err_pulse", b_err, 1'b0);
        chk("b_valid_pulse", b_valid, 1'b0);
`ifdef DATA_MEMORY_BANK_PARITY_EN
        chk("b_perr", b_perr, 1'b0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            step(1'($urandom), 2'($urandom), 16'($urandom), 1'($urandom), ra);
        end

        // Reset during a read
        step(1'b0, 2'b00, 16'h0000, 1'b1, 16'h0003);
        #1 rst_n = 0;
        #1;
        chk("midrd_rdata", a_data, 16'h0000);
        chk("midrd_valid", a_valid, 1'b0);
        chk("midrd_ready", a_ready, 1'b0);
        chk("midrd_err", a_err, 1'b0);
        #1 rst_n = 1;
        model_reset(); cyc = 0;
        for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 16'hFFFF, 1'b1, 16'(i));

        // Reset mid-clear: clear restarts from index 0
        #1 rst_n = 0;
        #1;
        chk("midclr_ready", a_ready, 1'b0);
        chk("midclr_rdata", a_data, 16'h0000);
        #1 rst_n = 1;
        model_reset(); cyc = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 2'b00, 16'h0000, 1'b1, 16'(i));
        chk("reclear_len", cyc, 8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'b00, 16'h0000, 1'b1, 16'(i));
            chk("reclear_val", a_data, INIT_A);
        end

`ifdef DATA_MEMORY_BANK_PARITY_EN
        // Corrupt a stored parity bit: data unchanged, error flagged
        step(1'b1, 2'b11, 16'h00FF, 1'b0, 16'h0002);
        dut.u_array.mem[2][0][8] <= ~dut.u_array.mem[2][0][8];
        perr_exp = 1;
        step(1'b0, 2'b00, 16'h0000, 1'b1, 16'h0002);
        step(1'b1, 2'b11, 16'h00FF, 1'b0, 16'h0002);
        step(1'b0, 2'b00, 16'h0000, 1'b1, 16'h0002);
        chk("parity_clean", a_perr, 1'b0);
`endif

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_bank.md
Name: data_memory_bank

Overview:
- Parametrised successor to the RISC_16 fixed 8x16 data memory.
- Provides a real writable, readable RAM of DEPTH words x DATA_W bits, with a registered one-cycle read, per-byte write enables and out-of-range detection.
- Runs a post-reset clear sequence that writes INIT_VALUE into every word.
- Sits between the load/store stage and the writeback mux.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words; must be a power of two, 2..65536.
- ADDR_W, 16, width of mem_access_addr.
- INIT_VALUE, 0, value written to every word during the clear sequence.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_access_addr  in  ADDR_W  word address, shared by the read and write ports.
- mem_write_data  in  DATA_W  write data.
- mem_write_en  in  1  write request.
- mem_byte_en  in  DATA_W/8  byte lanes to write; bit i covers bits [8i+7:8i].
- mem_read  in  1  read request.
- mem_read_data  out  DATA_W  registered read data.
- mem_read_valid  out  1  one-cycle pulse: mem_read_data was updated this cycle.
- mem_ready  out  1  high when requests are accepted.
- mem_addr_err  out  1  one-cycle pulse for an out-of-range request.

Behaviour:
- Index width: IDX_W = clog2(DEPTH). The RAM index is mem_access_addr[IDX_W-1:0].
- States: CLEAR and RUN.
- Reset (asynchronous, any time, including mid-clear or mid-read):
  - State goes to CLEAR and the clear counter goes to 0.
  - mem_read_data = 0, mem_read_valid = 0, mem_ready = 0, mem_addr_err = 0.
  - RAM contents are not reset directly; they are overwritten by the clear sequence.
- CLEAR:
  - Each cycle, RAM[counter] <= INIT_VALUE and the counter increments.
  - When the write at counter = DEPTH-1 completes, the next state is RUN.
  - CLEAR lasts exactly DEPTH cycles after reset release.
  - mem_ready is 0 throughout. mem_write_en and mem_read are ignored: no write, no valid pulse, no error pulse.
- RUN:
  - mem_ready = 1 (registered, rises in the first RUN cycle).
- Write (RUN, mem_write_en = 1):
  - At the clock edge, each byte lane i with mem_byte_en[i] = 1 is updated from mem_write_data.
  - Lanes with mem_byte_en[i] = 0 are unchanged.
  - mem_byte_en = 0 is a legal no-op.
- Read (RUN, mem_read = 1):
  - The address is sampled at edge N.
  - mem_read_data and mem_read_valid = 1 appear after edge N (latency 1).
  - mem_read_data holds its value until the next accepted read. mem_read_valid is high for exactly one cycle per read.
  - Back-to-back reads in consecutive cycles give consecutive valid pulses (throughput 1 per cycle).
- Simultaneous read and write:
  - Same index: write-first. Read data is the merged result (new bytes on enabled lanes, old bytes on the others).
  - Different indices: both complete independently.
- Out-of-range: any bit of mem_access_addr[ADDR_W-1:IDX_W] is set while mem_write_en or mem_read is asserted in RUN.
  - mem_addr_err pulses 1 on the next cycle.
  - The write is suppressed.
  - The read still completes: mem_read_valid = 1, mem_read_data = 0.
  - When DEPTH = 2^ADDR_W no address is out of range.
- The RAM array must be inferable as a synchronous single-write-port block RAM, with read-first output and a bypass mux for write-first.

Optional Feature:
- Macro: DATA_MEMORY_BANK_PARITY_EN.
- Defined:
  - Each word stores one even-parity bit per byte lane, computed on write and written as 0 by CLEAR.
  - On a read, lane parity is checked. An extra output mem_parity_err (1 bit, reset 0) pulses with mem_read_valid if any lane mismatches.
  - Data is still returned unmodified.
  - Write-first forwarding forwards freshly computed parity, so no error is reported on a forwarded read.
- Undefined:
  - No parity storage and no mem_parity_err port.
  - Behaviour is otherwise identical.

Decomposition:
- Package data_memory_pkg holds:
  - the state enum (ST_CLEAR, ST_RUN);
  - the clog2 function;
  - the byte-merge function (old word, new word, byte enable -> merged word);
  - the per-lane parity function.
- One sub-module, data_memory_array: a plain DEPTH x (DATA_W [+ parity]) synchronous RAM with byte-lane write enable and registered read.
- The FSM, address check and forwarding live in data_memory_bank.

Test Plan:
- Reset clear, DEPTH = 8 for sim, INIT_VALUE = 16'hA5A5: release rst_n, drive mem_read every cycle -> mem_ready rises after exactly 8 cycles, no mem_read_valid before that, and reads of index 0..7 return 16'hA5A5.
- Byte write: write 16'h1234 to index 3 with byte_en 2'b11, then 16'hFF00 with byte_en 2'b10, then read 3 -> 16'hFF34 one cycle after the read request, with a single valid pulse.
- Write-first collision: in the same cycle write 16'hBEEF with byte_en 2'b01 and read index 5 (which holds 16'h1111) -> read data 16'h11EF, and a later read also returns 16'h11EF.
- Out-of-range, DEPTH = 256: write 16'hDEAD to addr 16'h0105 -> mem_addr_err pulses and index 5 is unchanged. Read addr 16'h0105 -> valid with data 0 and mem_addr_err pulses.
- Reset mid-operation: assert rst_n low during a read and again mid-clear -> outputs go to 0 immediately, the clear restarts from index 0, and mem_ready returns after DEPTH cycles.
- Parity (macro defined): write 16'h00FF, force-flip one stored bit via hierarchical access, read -> mem_parity_err = 1 with valid. Repeat without the flip -> 0.
